data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/data_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

    // Load/store width codes, encoded as the funct3 field of the access.
    typedef enum logic [2:0] {
        B  = 3'b000,
        H  = 3'b001,
        W  = 3'b010,
        BU = 3'b100,
        HU = 3'b101
    } addrctl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    // True for the five width codes the responder understands.
    function automatic logic ctlLegal(input logic [2:0] code);
        case (code)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store strobes, store data
// replicated across lanes, and sign/zero-extended load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  laneAddr,
    input  logic [2:0]  addrCtl,
    input  logic [31:0] storeData,
    input  logic [31:0] memWord,
    output logic [3:0]  byteStrb,
    output logic [31:0] storeRep,
    output logic [31:0] loadData
);

    function automatic logic [31:0] extByte(input logic [7:0] val, input logic sgn);
        return {{24{sgn & val[7]}}, val};
    endfunction

    function automatic logic [31:0] extHalf(input logic [15:0] val, input logic sgn);
        return {{16{sgn & val[15]}}, val};
    endfunction

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    assign laneByte = memWord[{laneAddr, 3'b000} +: 8];
    assign laneHalf = laneAddr[1] ? memWord[31:16] : memWord[15:0];

    // Lane selection and extension per width code; illegal codes touch nothing.
    always_comb begin
        byteStrb = 4'b0000;
        storeRep = '0;
        loadData = '0;
        case (addrctl_e'(addrCtl))
            B, BU: begin
                byteStrb = 4'b0001 << laneAddr;
                storeRep = {4{storeData[7:0]}};
                loadData = extByte(laneByte, (addrCtl == B));
            end
            H, HU: begin
                byteStrb = laneAddr[1] ? 4'b1100 : 4'b0011;
                storeRep = {2{storeData[15:0]}};
                loadData = extHalf(laneHalf, (addrCtl == H));
            end
            W: begin
                byteStrb = 4'b1111;
                storeRep = storeData;
                loadData = memWord;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: one outstanding request, fixed extra latency of
// WAIT_CYCLES, response held until the consumer takes it.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W accesses
// report rsp_err instead of being silently aligned down.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_addrctl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state, nextState;
    logic [3:0]  waitCnt;
    logic        accept, commit, rspFire;

    logic        reqWe_p1;
    logic [31:0] reqAddr_p1, reqWdata_p1;
    logic [2:0]  reqCtl_p1;

    logic        effWe;
    logic [31:0] effAddr, effWdata;
    logic [2:0]  effCtl;

    logic        outOfRange, illegalCtl, alignErr, accessErr;
    logic [1:0]  laneAddr;
    logic [IDX_W-1:0] memIdx;
    logic [31:0] memWord;
    logic [3:0]  byteStrb;
    logic [31:0] storeRep, loadData;

    logic        vld_p2, err_p2;
    logic [31:0] rdata_p2;

    logic [31:0] mem [DEPTH_WORDS];

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state <= nextState;
            if (accept)
                waitCnt <= WAIT_LOAD;
            else if (state == WAIT && waitCnt != 4'd0)
                waitCnt <= waitCnt - 4'd1;
        end
    end

    // Next-state logic and the request/response handshakes.
    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        rspFire   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst;
                if (req_valid && rst)
                    nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (waitCnt == 4'd0)
                    nextState = RESP;
            end
            RESP: begin
                rspFire = vld_p2 && rsp_ready;
                if (rspFire)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;
    // The access takes effect only on the edge that enters RESP.
    assign commit = rst && (nextState == RESP) && (state != RESP);

    // ---- stage p1: request captured at accept ----
    // Latch the accepted request for the duration of the wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reqWe_p1    <= 1'b0;
            reqAddr_p1  <= '0;
            reqWdata_p1 <= '0;
            reqCtl_p1   <= 3'b000;
        end else if (accept) begin
            reqWe_p1    <= req_we;
            reqAddr_p1  <= req_addr;
            reqWdata_p1 <= req_wdata;
            reqCtl_p1   <= req_addrctl;
        end
    end

    // With zero wait the commit edge is the accept edge, so use the live request.
    assign effWe    = (state == IDLE) ? req_we      : reqWe_p1;
    assign effAddr  = (state == IDLE) ? req_addr    : reqAddr_p1;
    assign effWdata = (state == IDLE) ? req_wdata   : reqWdata_p1;
    assign effCtl   = (state == IDLE) ? req_addrctl : reqCtl_p1;

    assign outOfRange = {2'b00, effAddr[31:2]} >= 32'(DEPTH_WORDS);
    assign illegalCtl = !ctlLegal(effCtl);

    // Align the lane address down to the access width; optionally trap instead.
    always_comb begin
        alignErr = 1'b0;
        laneAddr = effAddr[1:0];
        case (addrctl_e'(effCtl))
            H, HU: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                alignErr = effAddr[0];
`endif
                laneAddr = {effAddr[1], 1'b0};
            end
            W: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                alignErr = |effAddr[1:0];
`endif
                laneAddr = 2'b00;
            end
            default: ;
        endcase
    end

    assign accessErr = outOfRange | illegalCtl | alignErr;
    assign memIdx    = effAddr[IDX_W+1:2];
    assign memWord   = outOfRange ? 32'd0 : mem[memIdx];

    dmem_lane_align uLaneAlign (
        .laneAddr  (laneAddr),
        .addrCtl   (effCtl),
        .storeData (effWdata),
        .memWord   (memWord),
        .byteStrb  (byteStrb),
        .storeRep  (storeRep),
        .loadData  (loadData)
    );

    // Storage write: strobed byte lanes, never reset.
    always_ff @(posedge clk) begin
        if (commit && effWe && !accessErr) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (byteStrb[b])
                    mem[memIdx][8*b +: 8] <= storeRep[8*b +: 8];
            end
        end
    end

    // ---- stage p2: registered response ----
    // Response register, loaded at commit and cleared on handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else if (commit) begin
            vld_p2   <= 1'b1;
            err_p2   <= accessErr;
            rdata_p2 <= (accessErr || effWe) ? 32'd0 : loadData;
        end else if (rspFire) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_err   = err_p2;
    assign rsp_rdata = rdata_p2;

endmodule
